// File: rtl/uart_rx_cfg.sv
// UART receiver with runtime baud divisor, parity and stop-bit configuration, 3-sample
// majority voting, valid/ready output handshake, overrun and break detection.
module uart_rx_cfg #(
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned NUM_SAMPLES  = 16,
   parameter int unsigned SAMPLE_CNT_W = 4,
   parameter int unsigned CLK_DIV_W    = 16
) (
   input  logic                  sys_clk,
   input  logic                  rst,
   input  logic                  rx,
   input  logic [CLK_DIV_W-1:0]  baud_div,
   input  logic [1:0]            parity_mode,
   input  logic                  two_stop,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   input  logic                  data_ready,
   output logic                  parity_err,
   output logic                  frame_err,
   output logic                  overrun,
   output logic                  break_det
);

   localparam int unsigned BitCntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BitCntW-1:0]      BitLast = BitCntW'(DATA_WIDTH - 1);
   localparam logic [SAMPLE_CNT_W-1:0] SmpLo   = SAMPLE_CNT_W'(NUM_SAMPLES / 2 - 1);
   localparam logic [SAMPLE_CNT_W-1:0] SmpMid  = SAMPLE_CNT_W'(NUM_SAMPLES / 2);
   localparam logic [SAMPLE_CNT_W-1:0] SmpDec  = SAMPLE_CNT_W'(NUM_SAMPLES / 2 + 1);
   localparam logic [SAMPLE_CNT_W-1:0] SmpLast = SAMPLE_CNT_W'(NUM_SAMPLES - 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBrkWait} state_e;

   state_e                  state_q;
   logic                    rx_meta_q, rx_sync_q, rx_prev_q;
   logic [CLK_DIV_W-1:0]    div_q;
   logic [SAMPLE_CNT_W-1:0] smp_q;
   logic [BitCntW-1:0]      bit_q;
   logic [DATA_WIDTH-1:0]   shift_q;
   logic                    smp_a_q, smp_b_q;
   logic [1:0]              par_mode_q;
   logic                    two_stop_q, stop2_q, perr_q, ferr_q, allzero_q;

   logic tick, decide, vote, fall, par_en, par_odd, stop_final;

   assign tick       = (div_q == '0);
   assign decide     = tick && (smp_q == SmpDec);
   assign vote       = (smp_a_q & smp_b_q) | (smp_a_q & rx_sync_q) | (smp_b_q & rx_sync_q);
   assign fall       = rx_prev_q & ~rx_sync_q;
   assign par_en     = (par_mode_q == 2'b01) || (par_mode_q == 2'b10);
   assign par_odd    = (par_mode_q == 2'b10);
   assign stop_final = !two_stop_q || stop2_q;

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
      end
   end

   // Free-running tick; a new baud_div is only picked up on reload.
   always_ff @(posedge sys_clk) begin
      if (rst)       div_q <= '0;
      else if (tick) div_q <= baud_div;
      else           div_q <= div_q - 1'b1;
   end

   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q    <= StIdle;
         smp_q      <= '0;
         bit_q      <= '0;
         shift_q    <= '0;
         smp_a_q    <= 1'b1;
         smp_b_q    <= 1'b1;
         par_mode_q <= 2'b00;
         two_stop_q <= 1'b0;
         stop2_q    <= 1'b0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         allzero_q  <= 1'b0;
         data_out   <= '0;
         data_valid <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
         break_det  <= 1'b0;
      end else begin
         break_det <= 1'b0;
         if (data_valid && data_ready) begin
            data_valid <= 1'b0;
            overrun    <= 1'b0;
         end
         if (tick) smp_q <= (smp_q == SmpLast) ? '0 : smp_q + 1'b1;
         if (tick && smp_q == SmpLo)  smp_a_q <= rx_sync_q;
         if (tick && smp_q == SmpMid) smp_b_q <= rx_sync_q;

         unique case (state_q)
            StIdle: begin
               if (fall) begin
                  state_q    <= StStart;
                  smp_q      <= '0;
                  bit_q      <= '0;
                  par_mode_q <= parity_mode;
                  two_stop_q <= two_stop;
                  stop2_q    <= 1'b0;
                  perr_q     <= 1'b0;
                  ferr_q     <= 1'b0;
                  allzero_q  <= 1'b1;
               end
            end
            StStart: begin
               if (decide) state_q <= vote ? StIdle : StData;
            end
            StData: begin
               if (decide) begin
                  shift_q   <= {vote, shift_q[DATA_WIDTH-1:1]};
                  allzero_q <= allzero_q & ~vote;
                  if (bit_q == BitLast) state_q <= par_en ? StParity : StStop;
                  else                  bit_q   <= bit_q + 1'b1;
               end
            end
            StParity: begin
               if (decide) begin
                  perr_q    <= vote ^ (^shift_q) ^ par_odd;
                  allzero_q <= allzero_q & ~vote;
                  state_q   <= StStop;
               end
            end
            StStop: begin
               if (decide && !stop_final) begin
                  stop2_q   <= 1'b1;
                  ferr_q    <= ferr_q | ~vote;
                  allzero_q <= allzero_q & ~vote;
               end else if (decide) begin
                  state_q   <= vote ? StIdle : StBrkWait;
                  break_det <= allzero_q & ~vote;
                  // Full output with no acceptance this cycle: keep the old word.
                  if (!data_valid || data_ready) begin
                     data_out   <= shift_q;
                     parity_err <= perr_q;
                     frame_err  <= ferr_q | ~vote;
                     data_valid <= 1'b1;
                  end else begin
                     overrun <= 1'b1;
                  end
               end
            end
            StBrkWait: begin
               if (rx_sync_q) state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: frames are driven bit by bit, expected words come from a
// frame-level model and are checked every cycle the output is valid.
module tb_uart_rx_cfg;

   logic        sys_clk = 1'b0;
   logic        rst;
   logic        rx;
   logic [15:0] baud_div;
   logic [1:0]  parity_mode;
   logic        two_stop;
   logic [7:0]  data_out;
   logic        data_valid;
   logic        data_ready;
   logic        parity_err, frame_err, overrun, break_det;

   int checks = 0;
   int failures = 0;
   int words_seen = 0;
   int brk_seen = 0;

   typedef struct packed {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
      logic       brk;
   } exp_t;

   exp_t expq[$];

   uart_rx_cfg #(
      .DATA_WIDTH  (8),
      .NUM_SAMPLES (16),
      .SAMPLE_CNT_W(4),
      .CLK_DIV_W   (16)
   ) dut (
      .sys_clk    (sys_clk),
      .rst        (rst),
      .rx         (rx),
      .baud_div   (baud_div),
      .parity_mode(parity_mode),
      .two_stop   (two_stop),
      .data_out   (data_out),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .break_det  (break_det)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // What the receiver must report for a frame, derived from the line contents alone.
   function automatic exp_t model(input logic [7:0] d, input logic [1:0] pm, input logic pbit,
                                  input logic two, input logic s1, input logic s2);
      exp_t e;
      logic par_en;
      int   ones;
      par_en = (pm == 2'd1) || (pm == 2'd2);
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      e.data = d;
      // Even mode wants an even total count of ones, odd mode an odd total.
      e.perr = par_en && (((ones + int'(pbit)) % 2) != ((pm == 2'd2) ? 1 : 0));
      e.ferr = (s1 == 1'b0) || (two && s2 == 1'b0);
      e.brk  = (d == 8'h00) && (!par_en || pbit == 1'b0) && !s1 && (!two || !s2);
      return e;
   endfunction

   // Called at posedge+1; leaves at posedge+1 one bit time later.
   task automatic drive_bit(input logic b);
      int n;
      n = 16 * (int'(baud_div) + 1);
      rx = b;
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic [1:0] pm, input logic pbit,
                             input logic two, input logic s1, input logic s2,
                             input bit expect_word);
      if (expect_word) expq.push_back(model(d, pm, pbit, two, s1, s2));
      parity_mode = pm;
      two_stop = two;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      if (pm == 2'd1 || pm == 2'd2) drive_bit(pbit);
      drive_bit(s1);
      if (two) drive_bit(s2);
      drive_bit(1'b1);
      drive_bit(1'b1);
   endtask

   // Every cycle the output holds a word, it must match the oldest outstanding expectation.
   always @(negedge sys_clk) begin
      if (!rst) begin
         if (break_det) begin
            brk_seen++;
            if (expq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL break_spurious: got break_det=1, expected no pending frame");
            end else begin
               check("break_frame", {31'd0, expq[0].brk}, 32'd1);
            end
         end
         if (data_valid) begin
            if (expq.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL spurious_valid: got data_out=%0h, expected no word", data_out);
            end else begin
               check("stream_data", {24'd0, data_out}, {24'd0, expq[0].data});
               check("stream_perr", {31'd0, parity_err}, {31'd0, expq[0].perr});
               check("stream_ferr", {31'd0, frame_err}, {31'd0, expq[0].ferr});
               if (data_ready) begin
                  void'(expq.pop_front());
                  words_seen++;
               end
            end
         end
      end
   end

   initial begin
      exp_t m;
      int   w0;
      rst = 1'b1;
      rx = 1'b1;
      baud_div = 16'd0;
      parity_mode = 2'd0;
      two_stop = 1'b0;
      data_ready = 1'b1;
      repeat (4) @(posedge sys_clk);
      @(negedge sys_clk);
      check("reset_valid", {31'd0, data_valid}, 32'd0);
      check("reset_data", {24'd0, data_out}, 32'd0);
      check("reset_flags", {28'd0, parity_err, frame_err, overrun, break_det}, 32'd0);
      @(posedge sys_clk); #1;
      rst = 1'b0;
      repeat (10) @(posedge sys_clk); #1;

      // Pin the model with hand-computed cases.
      m = model(8'hA5, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1);
      check("model_even_ok", {28'd0, m.perr, m.ferr, m.brk, 1'b0}, 32'd0);
      m = model(8'h3C, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1);
      check("model_odd_bad", {29'd0, m.perr, m.ferr, m.brk}, 32'b100);
      m = model(8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      check("model_break", {29'd0, m.perr, m.ferr, m.brk}, 32'b011);
      m = model(8'h5A, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0);
      check("model_stop2", {29'd0, m.perr, m.ferr, m.brk}, 32'b010);

      // Even parity, correct parity bit.
      send_frame(8'hA5, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      check("even_data", {24'd0, data_out}, 32'hA5);
      check("even_flags", {30'd0, parity_err, frame_err}, 32'd0);

      // Odd parity, wrong parity bit.
      send_frame(8'h3C, 2'd2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      check("odd_data", {24'd0, data_out}, 32'h3C);
      check("odd_perr", {31'd0, parity_err}, 32'd1);

      // Short low glitch must not start a frame.
      w0 = words_seen;
      parity_mode = 2'd0;
      rx = 1'b0;
      repeat (5) @(posedge sys_clk); #1;
      rx = 1'b1;
      repeat (60) @(posedge sys_clk); #1;
      check("glitch_valid", {31'd0, data_valid}, 32'd0);
      check("glitch_words", w0, words_seen);
      send_frame(8'h55, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      check("after_glitch", {24'd0, data_out}, 32'h55);
      check("after_glitch_words", words_seen, w0 + 1);

      // Overrun: second word dropped while the first is held.
      data_ready = 1'b0;
      send_frame(8'h11, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      send_frame(8'h22, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      check("ovr_data", {24'd0, data_out}, 32'h11);
      check("ovr_valid", {31'd0, data_valid}, 32'd1);
      check("ovr_flag", {31'd0, overrun}, 32'd1);
      data_ready = 1'b1;
      @(posedge sys_clk); #1;
      check("ovr_accept_valid", {31'd0, data_valid}, 32'd0);
      check("ovr_accept_flag", {31'd0, overrun}, 32'd0);
      check("ovr_hold_data", {24'd0, data_out}, 32'h11);

      // Line held low for three frame times: one break word, then silence.
      w0 = words_seen;
      expq.push_back(model(8'h00, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0));
      rx = 1'b0;
      repeat (3 * 10 * 16) @(posedge sys_clk); #1;
      check("brk_words", words_seen, w0 + 1);
      check("brk_pulses", brk_seen, 1);
      check("brk_data", {24'd0, data_out}, 32'h00);
      check("brk_ferr", {31'd0, frame_err}, 32'd1);
      rx = 1'b1;
      repeat (60) @(posedge sys_clk); #1;
      check("brk_silence", words_seen, w0 + 1);

      // Two stop bits, second one low.
      send_frame(8'h5A, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      check("stop2_data", {24'd0, data_out}, 32'h5A);
      check("stop2_ferr", {31'd0, frame_err}, 32'd1);

      // Reset in the middle of the data bits.
      two_stop = 1'b0;
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      drive_bit(1'b1);
      rst = 1'b1;
      rx = 1'b1;
      repeat (2) @(posedge sys_clk);
      @(negedge sys_clk);
      check("midrst_data", {24'd0, data_out}, 32'd0);
      check("midrst_flags", {27'd0, data_valid, parity_err, frame_err, overrun, break_det}, 32'd0);
      @(posedge sys_clk); #1;
      rst = 1'b0;
      baud_div = 16'd2;
      repeat (20) @(posedge sys_clk); #1;
      w0 = words_seen;
      send_frame(8'h81, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
      check("post_rst_data", {24'd0, data_out}, 32'h81);
      check("post_rst_flags", {30'd0, parity_err, frame_err}, 32'd0);
      check("post_rst_words", words_seen, w0 + 1);

      check("queue_drained", expq.size(), 0);
      check("brk_total", brk_seen, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
